// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, funct3 codes and address-split widths for the data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        WDONE  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEF_ADDRESS_WIDTH  = 32;
    localparam int DEF_SETS           = 16;
    localparam int DEF_WORDS_PER_LINE = 4;

    // Address split: tag | index | word | byte offset
    localparam int OFFSET_W = 2;
    localparam int WORD_W   = $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(DEF_SETS);
    localparam int TAG_W    = DEF_ADDRESS_WIDTH - INDEX_W - WORD_W - OFFSET_W;

endpackage

// File: rtl/dcache_align.sv
// rtl/dcache_align.sv - byte strobes, store lane replication and load extraction/extension
module dcache_align
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            mem_ctrl,
    input  logic [OFFSET_W-1:0]   offset,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_word,
    output logic [3:0]            strobe,
    output logic [DATA_WIDTH-1:0] lane_data,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: unknown codes fall back to a full-word write
    always_comb begin
        strobe    = 4'b1111;
        lane_data = store_data;
        case (mem_ctrl)
            F3_B, F3_BU: begin
                strobe    = 4'b0001 << offset;
                lane_data = {4{store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                strobe    = 4'b0011 << {offset[1], 1'b0};
                lane_data = {2{store_data[15:0]}};
            end
            default: begin
                strobe    = 4'b1111;
                lane_data = store_data;
            end
        endcase
    end

    // Load side: pick the lane, then sign- or zero-extend; halves ignore offset[0]
    always_comb begin
        byte_sel  = load_word[8*offset +: 8];
        half_sel  = load_word[16*offset[1] +: 16];
        load_data = load_word;
        case (mem_ctrl)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-through no-write-allocate data cache
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [2:0]               mem_ctrl,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int LINE_W = WORD_W + OFFSET_W;

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     beat_q;
    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

    logic [OFFSET_W-1:0]   offset;
    logic [WORD_W-1:0]     word;
    logic [INDEX_W-1:0]    index;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  last_beat;
    logic                  refill_ack;
    logic [3:0]            strobe;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] load_data;

    assign offset     = addr[OFFSET_W-1:0];
    assign word       = addr[LINE_W-1:OFFSET_W];
    assign index      = addr[LINE_W+INDEX_W-1:LINE_W];
    assign tag        = addr[ADDRESS_WIDTH-1:LINE_W+INDEX_W];
    assign hit        = valid_q[index] && (tag_q[index] == tag);
    assign last_beat  = (beat_q == WORD_W'(WORDS_PER_LINE - 1));
    assign refill_ack = (state_q == REFILL) && mem_ack;

    dcache_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .mem_ctrl   (mem_ctrl),
        .offset     (offset),
        .store_data (wdata),
        .load_word  (data_q[index][word]),
        .strobe     (strobe),
        .lane_data  (lane_data),
        .load_data  (load_data)
    );

    // Next state and all outputs; memory-side outputs are held purely by state plus the stalled request
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        rdata     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        stall   = 1'b1;
                        state_d = WRITE;
                    end else if (hit) begin
                        rdata = load_data;
                    end else begin
                        stall   = 1'b1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag, index, beat_q, {OFFSET_W{1'b0}}};
                if (mem_ack && last_beat) state_d = IDLE;
            end
            WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr[ADDRESS_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                mem_wdata = lane_data;
                mem_wstrb = strobe;
                if (mem_ack) state_d = WDONE;
            end
            WDONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, beat counter and valid bits; a line is invalid from miss detection until its last beat lands
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid && !req_write && !hit) begin
                beat_q         <= '0;
                valid_q[index] <= 1'b0;
            end
            if (refill_ack) begin
                beat_q <= beat_q + WORD_W'(1);
                if (last_beat) valid_q[index] <= 1'b1;
            end
        end
    end

    // Tag/data arrays: refill beats, and byte-merge of store hits on the store's IDLE edge
    always_ff @(posedge clk) begin
        if (!rst && refill_ack) begin
            data_q[index][beat_q] <= mem_rdata;
            if (last_beat) tag_q[index] <= tag;
        end
        if (!rst && state_q == IDLE && req_valid && req_write && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) data_q[index][word][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - randomized self-checking bench with a line-level cache model
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  mem_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_controller dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .mem_ctrl  (mem_ctrl),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: backing memory by word address, and a 16-line x 4-word cache image
    logic [31:0] bmem [int unsigned];
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_data  [16][4];

    function automatic logic [31:0] bread(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] c, input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (c)
            3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] st_strb(input logic [2:0] c, input logic [1:0] off);
        case (c)
            3'b000, 3'b100: return 4'(1 << off);
            3'b001, 3'b101: return off[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] st_shift(input logic [31:0] d, input logic [2:0] c, input logic [1:0] off);
        case (c)
            3'b000, 3'b100: return (d & 32'hFF) << (8 * off);
            3'b001, 3'b101: return (d & 32'hFFFF) << (16 * off[1]);
            default:        return d;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    // One complete request from its first IDLE cycle until the pipeline may issue the next one
    task automatic access(input bit wr, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] base, waddr, expd, mask, merged;
        logic [3:0]  sb;
        int          idx, wi, dly;
        logic [23:0] tg;
        bit          hit;
        base  = a & 32'hFFFF_FFF0;
        waddr = a & 32'hFFFF_FFFC;
        idx   = int'((a >> 4) & 32'hF);
        wi    = int'((a >> 2) & 32'h3);
        tg    = a[31:8];
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        got   = 32'h0;
        mem_ack = 1'b0; req_valid = 1'b1; req_write = wr; mem_ctrl = c; addr = a; wdata = wd;
        #1;
        if (!wr && hit) begin
            chk("hit_stall", stall, 0);
            chk("hit_memreq", mem_req, 0);
            chk("hit_rdata", rdata, ld_ext(m_data[idx][wi], c, a[1:0]));
            got = rdata;
            @(negedge clk);
        end else if (!wr) begin
            chk("miss_stall", stall, 1);
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                dly = $urandom_range(0, 2);
                for (int k = 0; k < dly; k++) begin
                    mem_rdata = $urandom; #1;
                    chk("rf_wait_ctl", {stall, mem_req, mem_we}, 3'b110);
                    chk("rf_wait_addr", mem_addr, base + 4 * b);
                    @(negedge clk);
                end
                mem_ack = 1'b1; mem_rdata = bread(base + 4 * b); #1;
                chk("rf_ack_ctl", {stall, mem_req, mem_we}, 3'b110);
                chk("rf_ack_addr", mem_addr, base + 4 * b);
                m_data[idx][b] = mem_rdata;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
            m_valid[idx] = 1'b1; m_tag[idx] = tg;
            #1;
            chk("rf_done_stall", stall, 0);
            chk("rf_done_memreq", mem_req, 0);
            chk("rf_done_rdata", rdata, ld_ext(m_data[idx][wi], c, a[1:0]));
            got = rdata;
            @(negedge clk);
        end else begin
            chk("st_stall", stall, 1);
            sb   = st_strb(c, a[1:0]);
            expd = st_shift(wd, c, a[1:0]);
            mask = byte_mask(sb);
            merged = (bread(waddr) & ~mask) | (expd & mask);
            bmem[waddr] = merged;
            if (hit) m_data[idx][wi] = (m_data[idx][wi] & ~mask) | (expd & mask);
            @(negedge clk);
            dly = $urandom_range(0, 2);
            for (int k = 0; k <= dly; k++) begin
                if (k == dly) mem_ack = 1'b1;
                #1;
                chk("wr_ctl", {stall, mem_req, mem_we}, 3'b111);
                chk("wr_addr", mem_addr, waddr);
                chk("wr_strb", mem_wstrb, sb);
                chk("wr_data", mem_wdata & mask, expd & mask);
                @(negedge clk);
            end
            mem_ack = 1'b0; #1;
            chk("wdone_stall", stall, 0);
            chk("wdone_memreq", mem_req, 0);
            chk("wdone_rdata", rdata, 0);
            @(negedge clk);
        end
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_write = $urandom_range(0, 1); addr = $urandom;
        mem_ack = $urandom_range(0, 1); #1;
        chk("idle_stall", stall, 0);
        chk("idle_memreq", mem_req, 0);
        chk("idle_rdata", rdata, 0);
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [2:0]  lcodes [8];
        logic [2:0]  scodes [5];
        lcodes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        scodes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; mem_ctrl = 3'b010;
        addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        chk("reset_stall", stall, 0);
        chk("reset_memreq", mem_req, 0);
        chk("reset_memwe", mem_we, 0);
        chk("reset_rdata", rdata, 0);
        @(negedge clk);

        bmem[32'h100] = 32'h0000_00A0;
        bmem[32'h104] = 32'h0000_00A1;
        bmem[32'h108] = 32'h0000_00A2;
        bmem[32'h10C] = 32'h80FF_1234;
        access(0, 3'b010, 32'h100, 0, got); chk("tp_lw100", got, 32'h0000_00A0);
        access(0, 3'b010, 32'h10C, 0, got); chk("tp_lw10c", got, 32'h80FF_1234);
        access(0, 3'b000, 32'h10F, 0, got); chk("tp_lb10f", got, 32'hFFFF_FF80);
        access(0, 3'b100, 32'h10F, 0, got); chk("tp_lbu10f", got, 32'h0000_0080);
        access(0, 3'b001, 32'h10E, 0, got); chk("tp_lh10e", got, 32'hFFFF_80FF);
        access(1, 3'b000, 32'h101, 32'h55, got);
        access(0, 3'b010, 32'h100, 0, got); chk("tp_sb_merge", got, 32'h0000_55A0);
        access(1, 3'b010, 32'h400, 32'hDEAD_BEEF, got);
        access(0, 3'b010, 32'h400, 0, got); chk("tp_sw_thru", got, 32'hDEAD_BEEF);
        access(0, 3'b010, 32'h100, 0, got); chk("tp_conf_a", got, 32'h0000_55A0);
        access(0, 3'b010, 32'h200, 0, got);
        access(0, 3'b010, 32'h100, 0, got); chk("tp_conf_again", got, 32'h0000_55A0);

        // Reset two beats into a refill, then the same line must refill from scratch
        req_valid = 1'b1; req_write = 1'b0; mem_ctrl = 3'b010; addr = 32'h300; #1;
        chk("rst_mid_stall", stall, 1);
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h1;
        @(negedge clk); mem_rdata = 32'h2;
        @(negedge clk); mem_ack = 1'b0; rst = 1'b1; req_valid = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_mid_memreq", mem_req, 0);
        chk("rst_mid_stall0", stall, 0);
        for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
        @(negedge clk);
        access(0, 3'b010, 32'h300, 0, got); chk("tp_rst_refill", got, bread(32'h300));

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int          kind;
            a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
            kind = $urandom_range(0, 9);
            if (kind < 2) idle_cycle();
            else if (kind < 7) access(0, lcodes[$urandom_range(0, 7)], a, 0, got);
            else access(1, scodes[$urandom_range(0, 4)], a, $urandom, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data cache. Sits between the pipeline memory stage and the word-wide backing data memory.
- It is the responder to the memory stage's load/store requests. It returns read data on a hit and asserts stall on a miss or a store.
- It is the initiator toward backing memory for line refills and store write-through.

Parameters:
DATA_WIDTH, 32, CPU and backing-memory word width
ADDRESS_WIDTH, 32, byte address width
SETS, 16, number of lines (power of two)
WORDS_PER_LINE, 4, words per line (power of two)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  memory-stage request present
req_write  input  1  1 = store, 0 = load
mem_ctrl  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  ADDRESS_WIDTH  byte address
wdata  input  DATA_WIDTH  store data (LSB-aligned)
rdata  output  DATA_WIDTH  extended load result
stall  output  1  hold pipeline; the request stays stable while high
mem_req  output  1  backing request
mem_we  output  1  backing write
mem_addr  output  ADDRESS_WIDTH  word-aligned backing address
mem_wdata  output  DATA_WIDTH  lane-shifted store data
mem_wstrb  output  4  byte strobes
mem_ack  input  1  backing completes one word this cycle
mem_rdata  input  DATA_WIDTH  refill word, valid with mem_ack

Behaviour:
- Address split:
  - offset = addr[1:0]
  - word = next log2(WORDS_PER_LINE) bits
  - index = next log2(SETS) bits
  - tag = remainder (24 bits at defaults)
- Reset:
  - state = IDLE
  - all valid bits cleared; tag/data arrays are not reset
  - stall = 0, mem_req = 0, mem_we = 0, rdata = 0
- Reset mid-operation: abandons any refill or write. A partially refilled line stays invalid.
- States: IDLE, REFILL, WRITE, WDONE.
- IDLE, load:
  - Hit (valid and tag match): rdata is combinational in the same cycle, stall = 0, no memory traffic.
  - Miss: stall = 1 combinationally, beat counter = 0, go to REFILL.
- IDLE, store:
  - stall = 1, go to WRITE.
  - On a hit, the cached bytes selected by the strobes are updated on the same clock edge. A store miss leaves the cache unchanged.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = line base + 4*beat.
  - Each mem_ack writes mem_rdata into word[beat] and increments beat.
  - On the ack for beat WORDS_PER_LINE-1: set valid, write tag, go to IDLE.
  - The held request then hits. Load miss latency = WORDS_PER_LINE acks + 1 cycle.
- WRITE:
  - mem_req = 1, mem_we = 1, mem_addr = {addr[hi:2], 2'b00}.
  - mem_wdata = wdata replicated into the lanes.
  - mem_wstrb: B = 1 << offset; H = 0011 << offset[1]*2; W = 1111.
  - On mem_ack go to WDONE.
- WDONE: stall = 0 for exactly one cycle, the request is ignored, go to IDLE. The same store is never issued twice.
- mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack. mem_ack while mem_req = 0 is ignored.
- stall is always 1 in REFILL and WRITE.
- Load extension:
  - B/H sign-extend; BU/HU zero-extend.
  - Selected lane = offset (byte) or offset[1] (half).
  - rdata = 0 whenever the access is not a load hit in IDLE.
- Alignment:
  - Misaligned halves/words are not supported; low offset bits are ignored (H uses offset[1], W uses none).
  - Undefined mem_ctrl codes are treated as W.
- req_valid = 0 in IDLE: no state change, stall = 0.

Decomposition:
- Shared package dcache_pkg:
  - state enum
  - mem_ctrl funct3 constants
  - derived widths (OFFSET_W, WORD_W, INDEX_W, TAG_W)
- One combinational sub-module, dcache_align: produces strobe generation, store lane replication and load extraction/extension. It is reused by the write-hit update path.

Test Plan:
- Reset, then LW 0x100: stall = 1, mem_addr 0x100/0x104/0x108/0x10C with acks returning 0xA0,0xA1,0xA2,0x80FF1234 -> stall drops one cycle after the last ack, rdata = 0xA0.
- LW 0x10C immediately after -> hit, stall = 0 the same cycle, rdata = 0x80FF1234, mem_req never rises. LB 0x10F -> 0xFFFFFF80; LBU 0x10F -> 0x00000080; LH 0x10E -> 0xFFFF80FF.
- SB 0x101, wdata 0x55 (hit) -> mem_we = 1, mem_addr 0x100, mem_wstrb 0010, mem_wdata byte1 = 0x55; stall held until ack, then exactly one WDONE cycle. A later LW 0x100 returns 0x000055A0 with no refill.
- SW 0x400 (miss) -> write-through only; a later LW 0x400 misses and refills.
- Conflict: LW 0x100 then LW 0x200 (both index 0) -> the second refills; a repeat LW 0x100 misses again.
- Assert rst after the second refill ack -> mem_req = 0 next cycle, state IDLE; a repeat LW of the same line performs a full 4-beat refill.
